mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, meaning: maximum wait cycles for mem_ack_i before forced completion (1..255).
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 Port clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port i_cs_i  input  1  instruction-side request strobe; held high until served.
REQ-006 Port i_we_i  input  1  instruction-side write enable.
REQ-007 Port i_addr_i  input  32  instruction-side word address.
REQ-008 Port i_data_i  input  32  instruction-side write data.
REQ-009 Port i_data_o  output  32  instruction-side read data; valid while i_ack_o is high.
REQ-010 Port i_ack_o  output  1  instruction-side one-cycle completion pulse.
REQ-011 Ports d_cs_i, d_we_i, d_addr_i, d_data_i, d_data_o, d_ack_o: same directions, widths and meanings as REQ-005..010, for the data side.
REQ-012 Port mem_cs_o  output  1  shared memory request.
REQ-013 Port mem_we_o  output  1  shared memory write enable.
REQ-014 Port mem_addr_o  output  32  shared memory address.
REQ-015 Port mem_data_o  output  32  shared memory write data.
REQ-016 Port mem_data_i  input  32  shared memory read data; valid with mem_ack_i.
REQ-017 Port mem_ack_i  input  1  shared memory completion.
REQ-018 Port err_o  output  1  sticky timeout flag.

Function
REQ-019 The FSM SHALL have states IDLE, BUSY and RESP.
REQ-020 In IDLE with at least one cs high, the arbiter SHALL latch the winner's we/addr/data and grant index and go to BUSY at the next edge.
REQ-021 With exactly one requester, that requester SHALL win.
REQ-022 With both requesting, the side not granted last SHALL win (round-robin); last_grant SHALL reset to data, so inst wins the first tie.
REQ-023 In BUSY, mem_cs_o SHALL be 1 and mem_we_o/mem_addr_o/mem_data_o SHALL come from the latched request, stable for the whole transaction.
REQ-024 Request-to-memory latency SHALL be 1 cycle: cs sampled in IDLE at edge t, mem_cs_o high from t.
REQ-025 In BUSY, mem_ack_i=1 SHALL register mem_data_i into the granted side's data_o and move to RESP; mem_cs_o SHALL drop in the same transition.
REQ-026 In RESP, only the granted side's ack_o SHALL be 1 for exactly one cycle; the FSM then returns to IDLE.
REQ-027 Each data_o SHALL hold its last value until that side's next completion; writes SHALL also update data_o, with mem_data_i.
REQ-028 Requesters drop cs in the cycle after ack_o. A cs still high when the FSM is in IDLE SHALL be treated as a new request; back-to-back requests from one side are therefore legal.
REQ-029 The ungranted side's cs, addr and data changes SHALL have no effect on the current transaction.
REQ-030 An 8-bit wait counter SHALL clear on entry to BUSY and increment each BUSY cycle without mem_ack_i.
REQ-031 When the counter reaches TIMEOUT, the FSM SHALL go to RESP, load 32'h0 into the granted data_o, and set err_o.
REQ-032 err_o SHALL clear only on rst.
REQ-033 mem_ack_i SHALL be ignored outside BUSY, including late acks after a timeout.
REQ-034 If mem_ack_i and the timeout coincide, the ack SHALL win: real data is loaded and err_o is not set.
REQ-035 Minimum transaction SHALL be 3 cycles (IDLE, BUSY with same-cycle ack, RESP); sustained throughput SHALL be one transaction per 3 cycles.

Reset
REQ-036 On rst, at the next edge: state=IDLE, last_grant=data, counter=0, err_o=0, all ack_o=0, mem_cs_o=0, mem_we_o=0, mem_addr_o=0, mem_data_o=0, i_data_o=0, d_data_o=0.
REQ-037 Reset asserted mid-transaction SHALL abandon the transaction: no ack_o is issued and a subsequent mem_ack_i is ignored.

Verification
REQ-038 Single read: i_cs_i=1, addr=0x40; memory acks after 8 cycles with 0x12345678 -> mem_addr_o=0x40, i_ack_o pulses once, i_data_o=0x12345678, d_ack_o stays 0.
REQ-039 Simultaneous requests twice in a row: both cs high after reset -> inst served first, then data; the second tie -> inst again, since data was last granted.
REQ-040 Data write: d_we_i=1, addr=0x8, data=0xA5A5A5A5 -> mem_we_o=1 with those values stable until mem_ack_i; d_ack_o pulses one cycle after the ack.
REQ-041 Timeout: TIMEOUT=16, no mem_ack_i -> ack_o after 16 BUSY cycles, data_o=0, err_o=1 and held; a late mem_ack_i is ignored.
REQ-042 Reset mid-BUSY: rst for 1 cycle, then mem_ack_i -> no ack_o, all outputs at reset values, next request served normally.
REQ-043 Back-to-back: i_cs_i held high across 4 requests with same-cycle ack -> 4 i_ack_o pulses spaced 3 cycles apart.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) round-robin arbiter in front of a single
// shared memory port. One transaction at a time: IDLE -> BUSY -> RESP.
// A per-transaction wait counter forces completion with zero data and a
// sticky error flag if the memory never acknowledges.
module mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_cs_i,
  input  logic        i_we_i,
  input  logic [31:0] i_addr_i,
  input  logic [31:0] i_data_i,
  output logic [31:0] i_data_o,
  output logic        i_ack_o,
  input  logic        d_cs_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_data_i,
  output logic [31:0] d_data_o,
  output logic        d_ack_o,
  output logic        mem_cs_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_ack_i,
  output logic        err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Counter value seen in the last BUSY cycle before a forced completion.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic        last_grant;   // 1 = data side was granted most recently
  logic        grant;        // side owning the current transaction, 1 = data
  logic        gnt_sel;      // winner if a grant were made this cycle
  logic        any_req;
  logic        timeout_hit;
  logic [7:0]  wait_cnt;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_data;

  // On a tie the side that was not granted last wins.
  assign any_req     = i_cs_i | d_cs_i;
  assign gnt_sel     = d_cs_i & (~i_cs_i | ~last_grant);
  assign timeout_hit = (wait_cnt == WAIT_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; an ack takes priority over a coincident timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = BUSY;
      BUSY:    if (mem_ack_i || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; memory side presents the latched request.
  always_comb begin
    mem_cs_o   = (state == BUSY);
    mem_we_o   = (state == BUSY) & req_we;
    mem_addr_o = req_addr;
    mem_data_o = req_data;
    i_ack_o    = (state == RESP) & ~grant;
    d_ack_o    = (state == RESP) & grant;
  end

  // Request latch, grant history, wait counter, read data and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      grant      <= 1'b0;
      wait_cnt   <= 8'd0;
      req_we     <= 1'b0;
      req_addr   <= 32'd0;
      req_data   <= 32'd0;
      i_data_o   <= 32'd0;
      d_data_o   <= 32'd0;
      err_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant      <= gnt_sel;
            last_grant <= gnt_sel;
            wait_cnt   <= 8'd0;
            req_we     <= gnt_sel ? d_we_i   : i_we_i;
            req_addr   <= gnt_sel ? d_addr_i : i_addr_i;
            req_data   <= gnt_sel ? d_data_i : i_data_i;
          end
        end
        BUSY: begin
          if (mem_ack_i) begin
            if (grant) d_data_o <= mem_data_i;
            else       i_data_o <= mem_data_i;
          end else if (timeout_hit) begin
            if (grant) d_data_o <= 32'd0;
            else       i_data_o <= 32'd0;
            err_o <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter. A transaction-level model
// predicts the winner of each arbitration, the BUSY length and the data
// returned, and every observation is compared through check_val.
module tb_mem_arbiter;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_cs, i_we, d_cs, d_we;
  logic [31:0] i_addr, i_data, d_addr, d_data;
  logic [31:0] i_rdata, d_rdata;
  logic        i_ack, d_ack;
  logic        mem_cs, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model state.
  bit          m_last;   // 1 = data side granted last
  bit          m_err;
  logic [31:0] m_idata, m_ddata;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_cs_i     (i_cs),
    .i_we_i     (i_we),
    .i_addr_i   (i_addr),
    .i_data_i   (i_data),
    .i_data_o   (i_rdata),
    .i_ack_o    (i_ack),
    .d_cs_i     (d_cs),
    .d_we_i     (d_we),
    .d_addr_i   (d_addr),
    .d_data_i   (d_data),
    .d_data_o   (d_rdata),
    .d_ack_o    (d_ack),
    .mem_cs_o   (mem_cs),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_data_o (mem_wdata),
    .mem_data_i (mem_rdata),
    .mem_ack_i  (mem_ack),
    .err_o      (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full arbitration + transaction starting from IDLE with the current
  // request inputs. d: BUSY cycle index at which memory acks; ack_en=0
  // means memory never acks. late_ack drives a stray ack during RESP.
  task automatic serve(input int d, input bit ack_en, input bit late_ack,
                       input bit keep, output bit win, output int ack_cyc);
    logic [31:0] ea, ed, rd, exp_rd;
    bit ewe, hit;
    int len;
    win = d_cs && (!i_cs || !m_last);
    m_last = win;
    ea  = win ? d_addr : i_addr;
    ed  = win ? d_data : i_data;
    ewe = win ? d_we   : i_we;
    hit = ack_en && (d < TO);
    len = hit ? d + 1 : TO;
    exp_rd = 32'd0;
    step();
    for (int k = 0; k < len; k++) begin
      check_val("busy_cs", mem_cs, 1);
      check_val("busy_we", mem_we, ewe);
      check_val("busy_addr", mem_addr, ea);
      check_val("busy_wdata", mem_wdata, ed);
      check_val("busy_no_ack", i_ack | d_ack, 0);
      rd = $urandom;
      mem_rdata = rd;
      mem_ack = hit && (k == d);
      if (hit && k == d) exp_rd = rd;
      if (win) begin i_addr = $urandom; i_data = $urandom; end
      else     begin d_addr = $urandom; d_data = $urandom; end
      step();
    end
    if (!hit) m_err = 1'b1;
    if (win) m_ddata = exp_rd; else m_idata = exp_rd;
    mem_ack   = late_ack;
    mem_rdata = $urandom;
    ack_cyc = cyc;
    check_val("resp_i_ack", i_ack, !win);
    check_val("resp_d_ack", d_ack, win);
    check_val("resp_cs", mem_cs, 0);
    check_val("resp_idata", i_rdata, m_idata);
    check_val("resp_ddata", d_rdata, m_ddata);
    check_val("resp_err", err, m_err);
    step();
    mem_ack = 1'b0;
    check_val("idle_acks", {i_ack, d_ack}, 0);
    check_val("idle_cs", mem_cs, 0);
    check_val("idle_idata", i_rdata, m_idata);
    check_val("idle_ddata", d_rdata, m_ddata);
    check_val("idle_err", err, m_err);
    if (!keep) begin
      if (win) d_cs = 1'b0; else i_cs = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_last = 1'b1; m_err = 1'b0; m_idata = 32'd0; m_ddata = 32'd0;
  endtask

  initial begin
    bit w;
    int c0, c1;
    int r;
    rst = 1'b1;
    i_cs = 0; i_we = 0; i_addr = 0; i_data = 0;
    d_cs = 0; d_we = 0; d_addr = 0; d_data = 0;
    mem_ack = 0; mem_rdata = 0;
    model_reset();
    repeat (2) step();
    rst = 1'b0;
    check_val("rst_cs", mem_cs, 0);
    check_val("rst_we", mem_we, 0);
    check_val("rst_addr", mem_addr, 0);
    check_val("rst_acks", {i_ack, d_ack}, 0);
    check_val("rst_data", i_rdata | d_rdata, 0);
    check_val("rst_err", err, 0);

    // Single instruction read, ack after 8 BUSY cycles.
    i_cs = 1; i_we = 0; i_addr = 32'h40;
    begin : rd_single
      logic [31:0] a;
      a = 32'h40;
      w = m_last;
      serve(7, 1, 0, 0, w, c0);
      check_val("single_win", w, 0);
      check_val("single_addr_sent", a, 32'h40);
    end

    // Two ties in a row after the read: inst then data, inst then data.
    model_reset();
    rst = 1; step(); rst = 0;
    i_cs = 1; d_cs = 1; i_addr = 32'h100; d_addr = 32'h200;
    serve(2, 1, 0, 0, w, c0); check_val("tie1_first", w, 0);
    serve(1, 1, 0, 0, w, c0); check_val("tie1_second", w, 1);
    i_cs = 1; d_cs = 1; i_addr = 32'h104; d_addr = 32'h204;
    serve(0, 1, 0, 0, w, c0); check_val("tie2_first", w, 0);
    serve(3, 1, 0, 0, w, c0); check_val("tie2_second", w, 1);

    // Data write.
    d_cs = 1; d_we = 1; d_addr = 32'h8; d_data = 32'hA5A5A5A5;
    serve(4, 1, 0, 0, w, c0); check_val("write_win", w, 1);
    d_we = 0;

    // Ack coincides with the timeout: ack wins, no error.
    i_cs = 1; i_addr = 32'h300;
    serve(TO - 1, 1, 0, 0, w, c0);

    // Back-to-back instruction requests, same-cycle ack.
    i_cs = 1;
    serve(0, 1, 0, 1, w, c0);
    for (int n = 0; n < 3; n++) begin
      serve(0, 1, 0, (n != 2), w, c1);
      check_val("b2b_gap", c1 - c0, 3);
      c0 = c1;
    end

    // Randomized traffic.
    for (int n = 0; n < 30; n++) begin
      if (!i_cs && !d_cs) begin
        r = $urandom_range(1, 3);
        if (r[0]) begin i_cs = 1; i_we = $urandom; i_addr = $urandom; i_data = $urandom; end
        if (r[1]) begin d_cs = 1; d_we = $urandom; d_addr = $urandom; d_data = $urandom; end
      end else if ($urandom_range(0, 1) == 1) begin
        if (!i_cs) begin i_cs = 1; i_we = $urandom; i_addr = $urandom; i_data = $urandom; end
        else if (!d_cs) begin d_cs = 1; d_we = $urandom; d_addr = $urandom; d_data = $urandom; end
      end
      serve($urandom_range(0, 12), 1, 0, 0, w, c0);
    end
    i_cs = 0; d_cs = 0;

    // Timeout with a late ack during RESP; error stays set afterwards.
    i_cs = 1; i_addr = 32'h500;
    serve(0, 0, 1, 0, w, c0);
    d_cs = 1; d_addr = 32'h600;
    serve(2, 1, 0, 0, w, c0);

    // Reset in the middle of BUSY, then a stray ack.
    i_cs = 1; i_addr = 32'h700;
    step();
    check_val("midrst_busy", mem_cs, 1);
    rst = 1;
    step();
    rst = 0; i_cs = 0;
    model_reset();
    check_val("midrst_cs", mem_cs, 0);
    check_val("midrst_we", mem_we, 0);
    check_val("midrst_addr", mem_addr, 0);
    check_val("midrst_wdata", mem_wdata, 0);
    check_val("midrst_data", {i_rdata, d_rdata} == 64'd0, 1);
    check_val("midrst_err", err, 0);
    mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    step();
    mem_ack = 0;
    check_val("midrst_no_ack", {i_ack, d_ack}, 0);
    check_val("midrst_idata", i_rdata, 0);
    check_val("midrst_idle", mem_cs, 0);

    // Normal request after the reset.
    i_cs = 1; d_cs = 1; i_addr = 32'h800; d_addr = 32'h900;
    serve(1, 1, 0, 0, w, c0); check_val("post_rst_win", w, 0);
    serve(0, 1, 0, 0, w, c0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
